sv_sata_xcvr_reconf_resp: RTL
=============================

# sv_sata_xcvr_reconf_resp

Responder for the transceiver reconfiguration register interface: the target side of the bus that `sv_sata_xcvr_reconf` drives. It implements the streamer register window (channel, control/status, offset, data) with configurable waitrequest stalls and status-busy duration. It holds a shadow parameter memory and reports each committed parameter write on a commit port. It serves as the synthesizable stand-in for the vendor reconfiguration IP in simulation and in bring-up builds, and as a write monitor.

## Interface
- `ACCESS_WAIT`, default 1: cycles `recfg_busy` is held high per access before acceptance; 0 gives zero-wait.
- `BUSY_CYCLES`, default 8: cycles status bit 8 stays set per operation; minimum 1.
- `SHADOW_DEPTH`, default 32: number of 32-bit shadow words; must be a power of 2.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `recfg_addr`  in  7  word address.
- `recfg_wreq`  in  1  write request, held until accepted.
- `recfg_wdat`  in  32  write data.
- `recfg_rreq`  in  1  read request, held until accepted.
- `recfg_rdat`  out  32  read data; valid in the acceptance cycle.
- `recfg_busy`  out  1  waitrequest.
- `cmt_valid`  out  1  one-cycle pulse per completed write operation.
- `cmt_chan`  out  10  channel of the committed write.
- `cmt_offset`  out  16  offset of the committed write.
- `cmt_data`  out  32  data of the committed write.

## Operation
- Register map:
  - 0x38 CHAN: bits [9:0], read/write.
  - 0x3A CTRL/STATUS:
    - Write: bit0 = write op, bit1 = read op, bits [4:2] = mode.
    - Read: {22'b0, err[9], busy[8], 3'b0, mode[4:2], 2'b0}.
  - 0x3B OFFSET: bits [15:0], read/write.
  - 0x3C DATA: bits [31:0], read/write.
  - Other addresses: writes ignored, reads return 0.
- Access acceptance:
  - An access is accepted in the cycle where `(recfg_wreq|recfg_rreq) & ~recfg_busy`.
  - `recfg_busy = (recfg_wreq|recfg_rreq) & (acc_cnt < ACCESS_WAIT)`.
  - `acc_cnt` increments while a request is stalled and clears on acceptance.
  - If `wreq` and `rreq` are asserted together, the write wins and no read occurs.
- Read data: `recfg_rdat` is a combinational mux of the register selected by `recfg_addr` while `rreq` is high, and 0 otherwise.
- Op FSM states: `IDLE` and `OP`.
  - In `IDLE`, an accepted CTRL write with bit0 or bit1 set enters `OP`. It clears `err`, latches mode, and loads `op_cnt = BUSY_CYCLES`.
  - The write starts no op and sets `err` when any of these hold:
    - mode != 3'b001;
    - bit0 and bit1 are both set;
    - OFFSET >= SHADOW_DEPTH (range check on all 16 bits).
  - A CTRL write with neither op bit set only updates mode.
  - In `OP`, `op_cnt` decrements each cycle. When it reaches 1, the FSM returns to `IDLE` on that edge and completes the op:
    - Write op: shadow[OFFSET] <= DATA and `cmt_valid` pulses.
    - Read op: DATA <= shadow[OFFSET].
  - Shadow index is `OFFSET[$clog2(SHADOW_DEPTH)-1:0]`.
- Writes to any register while in `OP` are accepted (not stalled), have no effect, and set `err`. `err` is sticky until the next op start.
- Reads are always allowed. STATUS busy = (state == `OP`).

## Timing
- Reset values: all registers, shadow, `err`, `op_cnt` and `cmt_*` are 0. `recfg_busy` is forced 0 while `reset_n` is low.
- Reset asserted mid-op aborts the op immediately: no commit, shadow cleared.
- With a CTRL write accepted at edge T:
  - STATUS busy reads 1 for cycles T+1 .. T+BUSY_CYCLES.
  - The shadow/DATA update and `cmt_valid` appear at T+BUSY_CYCLES+1, and busy reads 0 in that same cycle.
- Access latency: ACCESS_WAIT+1 cycles from request assertion to acceptance. A request held continuously after acceptance is treated as a new access.
- Register writes take effect on the acceptance edge. A read in the cycle after acceptance sees the new value.

## Structure
- Shared package `sv_xcvr_reconf_pkg`, also to be used by `sv_sata_xcvr_reconf`, holds:
  - address constants CHAN/CTRL/OFFSET/DATA (0x38/0x3A/0x3B/0x3C);
  - BUSY_BIT = 8, ERR_BIT = 9;
  - CTRL bit positions and MODE_STREAMER = 3'b001;
  - the FSM state enum.
- One sub-module: `sv_xcvr_reconf_shadow_ram`, the SHADOW_DEPTH x 32 register array with async clear, one write port and one combinational read port.

## Test plan
- Reset: hold `reset_n` = 0 with `wreq` = 1. Expect `recfg_busy` = 0 and all `cmt_*` = 0. After release, reads of 0x38/0x3A/0x3B/0x3C all return 0.
- ACCESS_WAIT = 2: write 0x38 = 0x3FF. Expect `busy` high for 2 cycles and low on the 3rd. A subsequent read of 0x38 returns 0x3FF.
- Pair with `sv_sata_xcvr_reconf` and issue cmd_reconfig with SATA_GEN3. Expect 4 `cmt_valid` pulses with chan 0:
  - offsets 0x00, 0x02, 0x0C, 0x16;
  - data 0x2840, 0x80D4, 0x5400, 0x0496;
  - `cmd_ready` returns to 1.
- Read op: OFFSET = 0x02 after the previous scenario, then CTRL = 0x6. STATUS bit 8 is set for 8 cycles, then DATA reads 0x80D4 and no `cmt_valid` occurs.
- OFFSET = 0x40 with CTRL = 0x5 at depth 32: expect STATUS = 0x204 (err set), no busy, no commit, shadow unchanged.
- Write DATA = 0xDEAD during `OP`: DATA is unchanged and err is set. Assert `reset_n` mid-op: STATUS reads 0 immediately and no commit occurs.

Source files
------------

// File: rtl/sv_xcvr_reconf_pkg.sv
// Shared definitions for the transceiver reconfiguration register window.
// Register addresses, status/control bit positions, op FSM states.
package sv_xcvr_reconf_pkg;

    localparam logic [6:0] ADDR_CHAN   = 7'h38;
    localparam logic [6:0] ADDR_CTRL   = 7'h3A;
    localparam logic [6:0] ADDR_OFFSET = 7'h3B;
    localparam logic [6:0] ADDR_DATA   = 7'h3C;

    localparam int BUSY_BIT = 8;
    localparam int ERR_BIT  = 9;

    localparam int CTRL_WR_BIT   = 0;
    localparam int CTRL_RD_BIT   = 1;
    localparam int CTRL_MODE_LSB = 2;

    localparam logic [2:0] MODE_STREAMER = 3'b001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OP   = 1'b1
    } op_state_e;

endpackage

// File: rtl/sv_xcvr_reconf_shadow_ram.sv
// Shadow parameter memory: DEPTH x 32 register array, async clear.
// Ports: clk, rst_n, we/waddr/wdata write port, raddr/rdata comb read.
module sv_xcvr_reconf_shadow_ram #(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sv_sata_xcvr_reconf_resp.sv
// Reconfiguration register responder: streamer window, shadow memory,
// commit port. Ports: recfg_* slave bus, cmt_* committed-write monitor.
module sv_sata_xcvr_reconf_resp
    import sv_xcvr_reconf_pkg::*;
#(
    parameter int ACCESS_WAIT  = 1,
    parameter int BUSY_CYCLES  = 8,
    parameter int SHADOW_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  recfg_addr,
    input  logic        recfg_wreq,
    input  logic [31:0] recfg_wdat,
    input  logic        recfg_rreq,
    output logic [31:0] recfg_rdat,
    output logic        recfg_busy,
    output logic        cmt_valid,
    output logic [9:0]  cmt_chan,
    output logic [15:0] cmt_offset,
    output logic [31:0] cmt_data
);

    localparam int AW = $clog2(SHADOW_DEPTH);

    op_state_e   state_q, state_d;
    logic [15:0] acc_cnt_q, acc_cnt_d;
    logic [15:0] op_cnt_q, op_cnt_d;
    logic [9:0]  chan_q, chan_d;
    logic [15:0] offset_q, offset_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  mode_q, mode_d;
    logic        err_q, err_d;
    logic        op_wr_q, op_wr_d;
    logic        cmt_valid_q, cmt_valid_d;
    logic [9:0]  cmt_chan_q, cmt_chan_d;
    logic [15:0] cmt_offset_q, cmt_offset_d;
    logic [31:0] cmt_data_q, cmt_data_d;

    logic        req, accept, wr_acc, op_bad;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] status;

    // Stall is masked in reset so a held request never sees waitrequest.
    assign req        = recfg_wreq | recfg_rreq;
    assign recfg_busy = reset_n & req & (acc_cnt_q < 16'(ACCESS_WAIT));
    assign accept     = req & ~recfg_busy;
    assign wr_acc     = accept & recfg_wreq;

    assign op_bad = (recfg_wdat[CTRL_MODE_LSB +: 3] != MODE_STREAMER)
                  | (recfg_wdat[CTRL_WR_BIT] & recfg_wdat[CTRL_RD_BIT])
                  | (32'(offset_q) >= SHADOW_DEPTH);

    always_comb begin
        status = '0;
        status[ERR_BIT] = err_q;
        status[BUSY_BIT] = (state_q == ST_OP);
        status[CTRL_MODE_LSB +: 3] = mode_q;
    end

    always_comb begin
        recfg_rdat = '0;
        if (recfg_rreq) begin
            unique case (recfg_addr)
                ADDR_CHAN:   recfg_rdat = {22'b0, chan_q};
                ADDR_CTRL:   recfg_rdat = status;
                ADDR_OFFSET: recfg_rdat = {16'b0, offset_q};
                ADDR_DATA:   recfg_rdat = data_q;
                default:     recfg_rdat = '0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        op_cnt_d     = op_cnt_q;
        chan_d       = chan_q;
        offset_d     = offset_q;
        data_d       = data_q;
        mode_d       = mode_q;
        err_d        = err_q;
        op_wr_d      = op_wr_q;
        cmt_valid_d  = 1'b0;
        cmt_chan_d   = cmt_chan_q;
        cmt_offset_d = cmt_offset_q;
        cmt_data_d   = cmt_data_q;
        ram_we       = 1'b0;

        // A request held after acceptance restarts the wait count.
        if (accept) begin
            acc_cnt_d = '0;
        end else if (req) begin
            acc_cnt_d = acc_cnt_q + 16'd1;
        end else begin
            acc_cnt_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wr_acc) begin
                    unique case (recfg_addr)
                        ADDR_CHAN:   chan_d = recfg_wdat[9:0];
                        ADDR_OFFSET: offset_d = recfg_wdat[15:0];
                        ADDR_DATA:   data_d = recfg_wdat;
                        ADDR_CTRL: begin
                            mode_d = recfg_wdat[CTRL_MODE_LSB +: 3];
                            if (recfg_wdat[CTRL_WR_BIT] |
                                recfg_wdat[CTRL_RD_BIT]) begin
                                if (op_bad) begin
                                    err_d = 1'b1;
                                end else begin
                                    state_d  = ST_OP;
                                    err_d    = 1'b0;
                                    op_cnt_d = 16'(BUSY_CYCLES);
                                    op_wr_d  = recfg_wdat[CTRL_WR_BIT];
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_OP: begin
                if (wr_acc) begin
                    err_d = 1'b1;
                end
                op_cnt_d = op_cnt_q - 16'd1;
                if (op_cnt_q == 16'd1) begin
                    state_d = ST_IDLE;
                    if (op_wr_q) begin
                        ram_we       = 1'b1;
                        cmt_valid_d  = 1'b1;
                        cmt_chan_d   = chan_q;
                        cmt_offset_d = offset_q;
                        cmt_data_d   = data_q;
                    end else begin
                        data_d = ram_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            acc_cnt_q    <= '0;
            op_cnt_q     <= '0;
            chan_q       <= '0;
            offset_q     <= '0;
            data_q       <= '0;
            mode_q       <= '0;
            err_q        <= 1'b0;
            op_wr_q      <= 1'b0;
            cmt_valid_q  <= 1'b0;
            cmt_chan_q   <= '0;
            cmt_offset_q <= '0;
            cmt_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            op_cnt_q     <= op_cnt_d;
            chan_q       <= chan_d;
            offset_q     <= offset_d;
            data_q       <= data_d;
            mode_q       <= mode_d;
            err_q        <= err_d;
            op_wr_q      <= op_wr_d;
            cmt_valid_q  <= cmt_valid_d;
            cmt_chan_q   <= cmt_chan_d;
            cmt_offset_q <= cmt_offset_d;
            cmt_data_q   <= cmt_data_d;
        end
    end

    sv_xcvr_reconf_shadow_ram #(
        .DEPTH (SHADOW_DEPTH)
    ) u_shadow (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (ram_we),
        .waddr (offset_q[AW-1:0]),
        .wdata (data_q),
        .raddr (offset_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign cmt_valid  = cmt_valid_q;
    assign cmt_chan   = cmt_chan_q;
    assign cmt_offset = cmt_offset_q;
    assign cmt_data   = cmt_data_q;

endmodule
